uno_cursor_ctrl: RTL

Upstream driver of the hand-selection highlight marker. It takes the three raw board push-buttons (left, right, confirm), synchronises and debounces them, and moves a selection index across the player's hand with wrap-around. It converts the index into the marker's top-left pixel coordinates (`x_pin`, `y_pin`) that feed the marker-draw stage. When the player confirms, it emits a one-cycle play request carrying the selected card index.

---
 rtl/uno_cursor_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uno_cursor_ctrl.sv
// rtl/uno_cursor_ctrl.sv - debounced hand-selection cursor with wrap, clamp and play request
module uno_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_SLOTS       = 16,
    parameter int X_ORIGIN        = 20,
    parameter int SLOT_PITCH      = 40,
    parameter int Y_ORIGIN        = 440
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       key_ok_n,
    input  logic       enable,
    input  logic [4:0] hand_count,
    output logic [3:0] sel_idx,
    output logic [9:0] x_pin,
    output logic [9:0] y_pin,
    output logic       cursor_visible,
    output logic       play_valid,
    output logic [3:0] play_idx
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]    X_BASE   = 10'(X_ORIGIN);
    localparam logic [9:0]    X_STEP   = 10'(SLOT_PITCH);
    localparam logic [9:0]    Y_ROW    = 10'(Y_ORIGIN);
    localparam logic [9:0]    HIDDEN   = 10'h3FF;
    localparam logic [4:0]    HC_MAX   = 5'(MAX_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    // Bit order for all per-key vectors: [0] left, [1] right, [2] ok
    logic [2:0]    key_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    db_n;
    logic [2:0]    evt;
    logic [CW-1:0] cnt [3];

    assign key_raw = {key_ok_n, key_right_n, key_left_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
            db_n  <= 3'b111;
            evt   <= 3'b000;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] != db_n[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        db_n[i] <= sync2[i];
                        cnt[i]  <= '0;
                        evt[i]  <= ~sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    state_t     state, state_nx;
    logic [3:0] sel_nx;
    logic       play_valid_nx;
    logic [3:0] play_idx_nx;
    logic [4:0] hc_eff;
    logic [3:0] hc_last;
    logic [3:0] sel_right;
    logic [3:0] sel_left;
    logic       shrunk;

    assign hc_eff    = (hand_count > HC_MAX) ? HC_MAX : hand_count;
    assign hc_last   = 4'(hc_eff - 5'd1);
    assign sel_right = (sel_idx == hc_last) ? 4'd0 : sel_idx + 4'd1;
    assign sel_left  = (sel_idx == 4'd0) ? hc_last : sel_idx - 4'd1;
    assign shrunk    = (hc_eff <= {1'b0, sel_idx});

    always_comb begin
        state_nx      = state;
        sel_nx        = sel_idx;
        play_valid_nx = 1'b0;
        play_idx_nx   = play_idx;
        if (!enable) begin
            state_nx = S_IDLE;
            sel_nx   = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    sel_nx = 4'd0;
                    if (hc_eff != 5'd0) state_nx = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (hc_eff == 5'd0) begin
                        state_nx = S_IDLE;
                        sel_nx   = 4'd0;
                    end else if (shrunk) begin
                        // Clamp wins even over confirm so a stale index is never played
                        sel_nx = hc_last;
                    end else if (evt[2]) begin
                        play_valid_nx = 1'b1;
                        play_idx_nx   = sel_idx;
                        state_nx      = S_DONE;
                    end else if (evt[1] && !evt[0]) begin
                        sel_nx = sel_right;
                    end else if (evt[0] && !evt[1]) begin
                        sel_nx = sel_left;
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx = S_IDLE;
                    sel_nx   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sel_idx    <= 4'd0;
            play_valid <= 1'b0;
            play_idx   <= 4'd0;
        end else begin
            state      <= state_nx;
            sel_idx    <= sel_nx;
            play_valid <= play_valid_nx;
            play_idx   <= play_idx_nx;
        end
    end

    // Coordinates are registered from the current state, so they trail sel_idx by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pin          <= HIDDEN;
            y_pin          <= HIDDEN;
            cursor_visible <= 1'b0;
        end else if (state != S_IDLE) begin
            x_pin          <= X_BASE + 10'(sel_idx) * X_STEP;
            y_pin          <= Y_ROW;
            cursor_visible <= 1'b1;
        end else begin
            x_pin          <= HIDDEN;
            y_pin          <= HIDDEN;
            cursor_visible <= 1'b0;
        end
    end

endmodule
